// File: rtl/attn_pkg.sv
// Shared types and constants for the attention decode-step sequencer.
package attn_pkg;

    // Sequencer states, one per engine phase plus a WAIT_* state per engine handshake.
    typedef enum logic [3:0] {
        StIdle,
        StProj,
        StWaitProj,
        StWriteKv,
        StLoad,
        StDrain,
        StQk,
        StWaitQk,
        StSm,
        StWaitSm,
        StAr,
        StWaitAr
    } state_e;

    // err_code values reported alongside done.
    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrFull    = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    // err_stage values. Timeouts can only fire in the four WAIT_* states, so a compact
    // 3-bit code identifies them instead of the full 4-bit state encoding.
    localparam logic [2:0] StageNone = 3'd0;
    localparam logic [2:0] StageProj = 3'd1;
    localparam logic [2:0] StageQk   = 3'd2;
    localparam logic [2:0] StageSm   = 3'd3;
    localparam logic [2:0] StageAr   = 3'd4;

    function automatic logic [2:0] stage_of(input state_e s);
        logic [2:0] code;
        case (s)
            StWaitProj: code = StageProj;
            StWaitQk:   code = StageQk;
            StWaitSm:   code = StageSm;
            StWaitAr:   code = StageAr;
            default:    code = StageNone;
        endcase
        return code;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/attn_rd_delay.sv
// Delays the cache read strobe and its chronological index by the cache read latency,
// producing the load-buffer write strobe and index.
module attn_rd_delay
    import attn_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned AW     = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_idx,
    output logic          o_we,
    output logic [AW-1:0] o_idx
);

    logic [RD_LAT-1:0] r_we_sr;
    logic [AW-1:0]     r_idx_sr [RD_LAT];

    // Shift the strobe and index together; stage 0 is one cycle behind the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we_sr <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_idx_sr[i] <= '0;
            end
        end else begin
            r_we_sr[0]  <= i_we;
            r_idx_sr[0] <= i_idx;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_we_sr[i]  <= r_we_sr[i-1];
                r_idx_sr[i] <= r_idx_sr[i-1];
            end
        end
    end

    assign o_we  = r_we_sr[RD_LAT-1];
    assign o_idx = r_idx_sr[RD_LAT-1];

endmodule

// File: rtl/attn_step_seq.sv
// Control sequencer for one multi-head-attention decode step. Tracks the live KV length,
// writes the new token into a ring or stop-when-full cache, streams cache reads in
// chronological order, and hands off to the QK, softmax and reader engines with a timeout
// on every handshake. Carries no datapath.
module attn_step_seq
    import attn_pkg::*;
#(
    parameter int unsigned D         = 64,
    parameter int unsigned SEQ_LEN   = 2048,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned WRAP_MODE = 1,
    parameter int unsigned TIMEOUT   = 65535,
    localparam int unsigned AW       = $clog2(SEQ_LEN),
    localparam int unsigned LW       = $clog2(SEQ_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_clear,
    output logic          o_proj_start,
    output logic          o_proj_valid,
    input  logic          i_proj_done,
    output logic          o_kv_we,
    output logic [AW-1:0] o_kv_waddr,
    output logic          o_kv_rd_en,
    output logic [AW-1:0] o_kv_raddr,
    output logic          o_ld_we,
    output logic [AW-1:0] o_ld_idx,
    output logic [LW-1:0] o_act_len,
    output logic          o_qk_start,
    output logic          o_sm_start,
    output logic          o_ar_start,
    input  logic          i_qk_done,
    input  logic          i_sm_done,
    input  logic          i_ar_done,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [1:0]    o_err_code,
    output logic [2:0]    o_err_stage
);

    // One counter serves the projection beats, the drain wait and the handshake timeout;
    // those phases never overlap.
    localparam int unsigned CW = $clog2(max3(D, RD_LAT, TIMEOUT) + 1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic [LW-1:0] r_len;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_idx;

    logic          r_proj_start;
    logic          r_proj_valid;
    logic          r_kv_we;
    logic [AW-1:0] r_kv_waddr;
    logic          r_kv_rd_en;
    logic [AW-1:0] r_kv_raddr;
    logic          r_qk_start;
    logic          r_sm_start;
    logic          r_ar_start;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_err_code;
    logic [2:0]    r_err_stage;

    logic          w_full;
    logic          w_reject;
    logic [LW-1:0] w_len_nx;
    logic [AW-1:0] w_wp_nx;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_raddr_inc;
    logic          w_last_rd;
    logic          w_timeout;
    logic          w_eng_done;

    assign w_full      = (r_len == LW'(SEQ_LEN));
    assign w_reject    = w_full && (WRAP_MODE == 0);
    assign w_len_nx    = w_full ? r_len : r_len + LW'(1);
    assign w_wp_nx     = (r_wr_ptr == AW'(SEQ_LEN - 1)) ? '0 : r_wr_ptr + AW'(1);
    // Once full, the oldest token sits just past the newest write.
    assign w_base      = (w_len_nx == LW'(SEQ_LEN)) ? w_wp_nx : '0;
    assign w_raddr_inc = (r_kv_raddr == AW'(SEQ_LEN - 1)) ? '0 : r_kv_raddr + AW'(1);
    assign w_last_rd   = (LW'(r_rd_idx) == r_len - LW'(1));
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    // Select the done input belonging to the current WAIT_* state; others are ignored.
    always_comb begin
        w_eng_done = 1'b0;
        unique case (r_state)
            StWaitProj: w_eng_done = i_proj_done;
            StWaitQk:   w_eng_done = i_qk_done;
            StWaitSm:   w_eng_done = i_sm_done;
            StWaitAr:   w_eng_done = i_ar_done;
            default:    w_eng_done = 1'b0;
        endcase
    end

    // Step FSM; outputs are registered and set on the transition into the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_len        <= '0;
            r_wr_ptr     <= '0;
            r_rd_idx     <= '0;
            r_proj_start <= 1'b0;
            r_proj_valid <= 1'b0;
            r_kv_we      <= 1'b0;
            r_kv_waddr   <= '0;
            r_kv_rd_en   <= 1'b0;
            r_kv_raddr   <= '0;
            r_qk_start   <= 1'b0;
            r_sm_start   <= 1'b0;
            r_ar_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ErrNone;
            r_err_stage  <= StageNone;
        end else begin
            // Single-cycle pulses and the done qualifiers default low.
            r_proj_start <= 1'b0;
            r_kv_we      <= 1'b0;
            r_qk_start   <= 1'b0;
            r_sm_start   <= 1'b0;
            r_ar_start   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ErrNone;
            r_err_stage  <= StageNone;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state      <= StProj;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_proj_valid <= 1'b1;
                        r_proj_start <= 1'b1;
                    end else if (i_clear) begin
                        r_len    <= '0;
                        r_wr_ptr <= '0;
                    end
                end
                StProj: begin
                    if (r_cnt == CW'(D - 1)) begin
                        r_state      <= StWaitProj;
                        r_proj_valid <= 1'b0;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StWriteKv: begin
                    if (w_reject) begin
                        r_state    <= StIdle;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_code <= ErrFull;
                    end else begin
                        r_state    <= StLoad;
                        r_wr_ptr   <= w_wp_nx;
                        r_len      <= w_len_nx;
                        r_kv_rd_en <= 1'b1;
                        r_kv_raddr <= w_base;
                        r_rd_idx   <= '0;
                    end
                end
                StLoad: begin
                    if (w_last_rd) begin
                        r_state    <= StDrain;
                        r_kv_rd_en <= 1'b0;
                        r_cnt      <= '0;
                    end else begin
                        r_rd_idx   <= r_rd_idx + AW'(1);
                        r_kv_raddr <= w_raddr_inc;
                    end
                end
                StDrain: begin
                    if (r_cnt == CW'(RD_LAT - 1)) begin
                        r_state    <= StQk;
                        r_qk_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StQk: begin
                    r_state <= StWaitQk;
                    r_cnt   <= '0;
                end
                StSm: begin
                    r_state <= StWaitSm;
                    r_cnt   <= '0;
                end
                StAr: begin
                    r_state <= StWaitAr;
                    r_cnt   <= '0;
                end
                StWaitProj, StWaitQk, StWaitSm, StWaitAr: begin
                    if (w_eng_done) begin
                        unique case (r_state)
                            StWaitProj: begin
                                r_state    <= StWriteKv;
                                r_kv_we    <= !w_reject;
                                r_kv_waddr <= r_wr_ptr;
                            end
                            StWaitQk: begin
                                r_state    <= StSm;
                                r_sm_start <= 1'b1;
                            end
                            StWaitSm: begin
                                r_state    <= StAr;
                                r_ar_start <= 1'b1;
                            end
                            default: begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_state     <= StIdle;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                        r_err_code  <= ErrTimeout;
                        r_err_stage <= stage_of(r_state);
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    attn_rd_delay #(
        .RD_LAT(RD_LAT),
        .AW    (AW)
    ) u_rd_delay (
        .clk  (clk),
        .rst  (rst),
        .i_we (r_kv_rd_en),
        .i_idx(r_rd_idx),
        .o_we (o_ld_we),
        .o_idx(o_ld_idx)
    );

    assign o_proj_start = r_proj_start;
    assign o_proj_valid = r_proj_valid;
    assign o_kv_we      = r_kv_we;
    assign o_kv_waddr   = r_kv_waddr;
    assign o_kv_rd_en   = r_kv_rd_en;
    assign o_kv_raddr   = r_kv_raddr;
    assign o_act_len    = r_len;
    assign o_qk_start   = r_qk_start;
    assign o_sm_start   = r_sm_start;
    assign o_ar_start   = r_ar_start;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    assign o_err_stage  = r_err_stage;

endmodule

// File: tb/tb_attn_step_seq.sv
// Directed bench for attn_step_seq: one ring-buffer and one stop-when-full instance share
// stimulus; checks are made against whichever instance `sel` points at.
module tb_attn_step_seq;

    localparam int D   = 4;
    localparam int SEQ = 8;
    localparam int RDL = 2;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, clear = 1'b0;
    logic proj_done = 1'b0, qk_done = 1'b0, sm_done = 1'b0, ar_done = 1'b0;

    logic       ps_a[2], pv_a[2], we_a[2], rd_a[2], ldwe_a[2];
    logic       qk_a[2], sm_a[2], ar_a[2], busy_a[2], done_a[2], err_a[2];
    logic [2:0] waddr_a[2], raddr_a[2], ldidx_a[2], stage_a[2];
    logic [3:0] len_a[2];
    logic [1:0] code_a[2];

    int sel = 0;
    int n_pass = 0, n_total = 0;

    int res_cycles, res_done, res_err, res_code, res_stage, res_len;
    int res_pv, res_ps, res_we, res_waddr, res_rd, res_ld, res_lag_bad, res_qk, res_sm_cyc;
    int rd_log[16], ld_log[16];

    always #5 clk = ~clk;

    attn_step_seq #(.D(D), .SEQ_LEN(SEQ), .RD_LAT(RDL), .WRAP_MODE(1), .TIMEOUT(TO)) dut_wrap (
        .clk(clk), .rst(rst), .i_start(start), .i_clear(clear),
        .o_proj_start(ps_a[0]), .o_proj_valid(pv_a[0]), .i_proj_done(proj_done),
        .o_kv_we(we_a[0]), .o_kv_waddr(waddr_a[0]), .o_kv_rd_en(rd_a[0]),
        .o_kv_raddr(raddr_a[0]), .o_ld_we(ldwe_a[0]), .o_ld_idx(ldidx_a[0]),
        .o_act_len(len_a[0]), .o_qk_start(qk_a[0]), .o_sm_start(sm_a[0]),
        .o_ar_start(ar_a[0]), .i_qk_done(qk_done), .i_sm_done(sm_done), .i_ar_done(ar_done),
        .o_busy(busy_a[0]), .o_done(done_a[0]), .o_err(err_a[0]), .o_err_code(code_a[0]),
        .o_err_stage(stage_a[0])
    );

    attn_step_seq #(.D(D), .SEQ_LEN(SEQ), .RD_LAT(RDL), .WRAP_MODE(0), .TIMEOUT(TO)) dut_stop (
        .clk(clk), .rst(rst), .i_start(start), .i_clear(clear),
        .o_proj_start(ps_a[1]), .o_proj_valid(pv_a[1]), .i_proj_done(proj_done),
        .o_kv_we(we_a[1]), .o_kv_waddr(waddr_a[1]), .o_kv_rd_en(rd_a[1]),
        .o_kv_raddr(raddr_a[1]), .o_ld_we(ldwe_a[1]), .o_ld_idx(ldidx_a[1]),
        .o_act_len(len_a[1]), .o_qk_start(qk_a[1]), .o_sm_start(sm_a[1]),
        .o_ar_start(ar_a[1]), .i_qk_done(qk_done), .i_sm_done(sm_done), .i_ar_done(ar_done),
        .o_busy(busy_a[1]), .o_done(done_a[1]), .o_err(err_a[1]), .o_err_code(code_a[1]),
        .o_err_stage(stage_a[1])
    );

    function automatic logic [28:0] outs(input int s);
        return {ps_a[s], pv_a[s], we_a[s], waddr_a[s], rd_a[s], raddr_a[s], ldwe_a[s],
                ldidx_a[s], len_a[s], qk_a[s], sm_a[s], ar_a[s], busy_a[s], done_a[s],
                err_a[s], code_a[s], stage_a[s]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 0; clear = 0; proj_done = 0; qk_done = 0; sm_done = 0; ar_done = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run one step; engines answer 3 cycles after their start (projection: 3 cycles after
    // the last beat). Cycle n counts negedges after the one that drives start.
    task automatic do_step(input bit with_clear, input bit stray, input bit drop_sm);
        int pdue, qdue, sdue, adue;
        int rd_cyc[16];
        bit prev_pv;
        res_cycles = -1; res_done = 0; res_err = -1; res_code = -1; res_stage = -1;
        res_len = -1; res_pv = 0; res_ps = 0; res_we = 0; res_waddr = -1; res_rd = 0;
        res_ld = 0; res_lag_bad = 0; res_qk = 0; res_sm_cyc = -1;
        pdue = -1; qdue = -1; sdue = -1; adue = -1; prev_pv = 0;
        for (int i = 0; i < 16; i++) begin
            rd_log[i] = -1; ld_log[i] = -1; rd_cyc[i] = -100;
        end
        @(negedge clk);
        start = 1'b1;
        clear = with_clear;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            start = 0; clear = 0; proj_done = 0; qk_done = 0; sm_done = 0; ar_done = 0;
            if (pv_a[sel]) res_pv++;
            if (ps_a[sel]) begin
                res_ps++;
                if (stray) qk_done = 1'b1;
            end
            if (stray && n == 2) start = 1'b1;
            if (prev_pv && !pv_a[sel]) pdue = n + 2;
            prev_pv = pv_a[sel];
            if (we_a[sel]) begin
                res_we++;
                res_waddr = int'(waddr_a[sel]);
            end
            if (rd_a[sel]) begin
                if (res_rd < 16) begin
                    rd_log[res_rd] = int'(raddr_a[sel]);
                    rd_cyc[res_rd] = n;
                end
                res_rd++;
            end
            if (ldwe_a[sel]) begin
                if (res_ld >= res_rd || res_ld >= 16) res_lag_bad++;
                else begin
                    ld_log[res_ld] = int'(ldidx_a[sel]);
                    if (rd_cyc[res_ld] + RDL != n) res_lag_bad++;
                end
                res_ld++;
            end
            if (qk_a[sel]) begin
                res_qk++;
                qdue = n + 3;
            end
            if (sm_a[sel]) begin
                res_sm_cyc = n;
                if (!drop_sm) sdue = n + 3;
            end
            if (ar_a[sel]) adue = n + 3;
            if (done_a[sel]) begin
                res_done = 1;
                res_cycles = n;
                res_err = int'(err_a[sel]);
                res_code = int'(code_a[sel]);
                res_stage = int'(stage_a[sel]);
                res_len = int'(len_a[sel]);
                break;
            end
            if (n == pdue) proj_done = 1'b1;
            if (n == qdue) qk_done = 1'b1;
            if (n == sdue) sm_done = 1'b1;
            if (n == adue) ar_done = 1'b1;
        end
        start = 0; clear = 0; proj_done = 0; qk_done = 0; sm_done = 0; ar_done = 0;
    endtask

    typedef struct {
        bit rst_before;
        int sel;
        int waddr;
        int len;
        int base;
        bit err;
        int code;
        int cycles;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // Ring buffer: ten steps from empty. Normal step length is 23 + len cycles.
        vecs[0]  = '{1, 0, 0, 1, 0, 0, 0, 24};
        vecs[1]  = '{0, 0, 1, 2, 0, 0, 0, 25};
        vecs[2]  = '{0, 0, 2, 3, 0, 0, 0, 26};
        vecs[3]  = '{0, 0, 3, 4, 0, 0, 0, 27};
        vecs[4]  = '{0, 0, 4, 5, 0, 0, 0, 28};
        vecs[5]  = '{0, 0, 5, 6, 0, 0, 0, 29};
        vecs[6]  = '{0, 0, 6, 7, 0, 0, 0, 30};
        vecs[7]  = '{0, 0, 7, 8, 0, 0, 0, 31};
        vecs[8]  = '{0, 0, 0, 8, 1, 0, 0, 31};
        vecs[9]  = '{0, 0, 1, 8, 2, 0, 0, 31};
        // Stop-when-full: eight good steps then a rejected ninth.
        vecs[10] = '{1, 1, 0, 1, 0, 0, 0, 24};
        vecs[11] = '{0, 1, 1, 2, 0, 0, 0, 25};
        vecs[12] = '{0, 1, 2, 3, 0, 0, 0, 26};
        vecs[13] = '{0, 1, 3, 4, 0, 0, 0, 27};
        vecs[14] = '{0, 1, 4, 5, 0, 0, 0, 28};
        vecs[15] = '{0, 1, 5, 6, 0, 0, 0, 29};
        vecs[16] = '{0, 1, 6, 7, 0, 0, 0, 30};
        vecs[17] = '{0, 1, 7, 8, 0, 0, 0, 31};
        vecs[18] = '{0, 1, 0, 8, 0, 1, 1, 9};

        repeat (3) @(negedge clk);
        chk("reset_outs_wrap", int'(outs(0)), 0);
        chk("reset_outs_stop", int'(outs(1)), 0);
        rst = 1'b0;

        for (int v = 0; v < 19; v++) begin
            if (vecs[v].rst_before) apply_reset();
            sel = vecs[v].sel;
            do_step(1'b0, 1'b0, 1'b0);
            chk($sformatf("v%0d_done", v), res_done, 1);
            chk($sformatf("v%0d_err", v), res_err, int'(vecs[v].err));
            chk($sformatf("v%0d_code", v), res_code, vecs[v].code);
            chk($sformatf("v%0d_act_len", v), res_len, vecs[v].len);
            chk($sformatf("v%0d_cycles", v), res_cycles, vecs[v].cycles);
            chk($sformatf("v%0d_proj_valid_beats", v), res_pv, D);
            chk($sformatf("v%0d_kv_we_count", v), res_we, vecs[v].err ? 0 : 1);
            chk($sformatf("v%0d_qk_start_count", v), res_qk, vecs[v].err ? 0 : 1);
            chk($sformatf("v%0d_rd_count", v), res_rd, vecs[v].err ? 0 : vecs[v].len);
            chk($sformatf("v%0d_ld_count", v), res_ld, vecs[v].err ? 0 : vecs[v].len);
            chk($sformatf("v%0d_ld_lag", v), res_lag_bad, 0);
            if (!vecs[v].err) begin
                chk($sformatf("v%0d_waddr", v), res_waddr, vecs[v].waddr);
                for (int i = 0; i < vecs[v].len; i++) begin
                    chk($sformatf("v%0d_raddr%0d", v, i), rd_log[i], (vecs[v].base + i) % SEQ);
                    chk($sformatf("v%0d_ld_idx%0d", v, i), ld_log[i], i);
                end
            end
        end

        // Softmax never answers: timeout 16 cycles after entering WAIT_SM.
        apply_reset();
        sel = 0;
        do_step(1'b0, 1'b0, 1'b1);
        chk("to_done", res_done, 1);
        chk("to_err", res_err, 1);
        chk("to_code", res_code, 2);
        chk("to_stage", res_stage, 3);
        chk("to_latency_from_sm_start", res_cycles - res_sm_cyc, 1 + TO);
        chk("to_act_len", res_len, 1);
        do_step(1'b0, 1'b0, 1'b0);
        chk("after_to_err", res_err, 0);
        chk("after_to_waddr", res_waddr, 1);
        chk("after_to_act_len", res_len, 2);
        chk("after_to_cycles", res_cycles, 25);

        // Stray qk_done during PROJ and a start while busy are both ignored.
        do_step(1'b0, 1'b1, 1'b0);
        chk("stray_err", res_err, 0);
        chk("stray_proj_start_count", res_ps, 1);
        chk("stray_proj_valid_beats", res_pv, D);
        chk("stray_cycles", res_cycles, 26);
        chk("stray_act_len", res_len, 3);

        // start together with clear: start wins, length keeps growing.
        do_step(1'b1, 1'b0, 1'b0);
        chk("start_clear_waddr", res_waddr, 3);
        chk("start_clear_act_len", res_len, 4);

        // clear alone in IDLE empties the cache.
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_act_len", int'(len_a[0]), 0);
        do_step(1'b0, 1'b0, 1'b0);
        chk("post_clear_waddr", res_waddr, 0);
        chk("post_clear_act_len", res_len, 1);
        chk("post_clear_raddr0", rd_log[0], 0);
        chk("post_clear_cycles", res_cycles, 24);

        // Reset while in LOAD aborts silently and empties the cache.
        begin
            bit hit;
            int dn;
            hit = 0;
            dn = 0;
            do_step(1'b0, 1'b0, 1'b0);
            @(negedge clk);
            start = 1'b1;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                start = 1'b0;
                if (n == 10) proj_done = 1'b1;
                else proj_done = 1'b0;
                if (rd_a[0]) begin
                    hit = 1;
                    break;
                end
            end
            chk("load_reached", int'(hit), 1);
            proj_done = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("midreset_outs", int'(outs(0)), 0);
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (done_a[0] || ldwe_a[0]) dn++;
            end
            chk("midreset_no_done", dn, 0);
            do_step(1'b0, 1'b0, 1'b0);
            chk("midreset_next_waddr", res_waddr, 0);
            chk("midreset_next_act_len", res_len, 1);
            chk("midreset_next_err", res_err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/attn_step_seq.md
Name: attn_step_seq

Overview:
- Parametrised sequencer for one decode step of multi-head attention.
- Replaces the fixed-length top-level FSM with one that tracks the live KV length, supports ring-buffer (sliding-window) or stop-when-full cache modes, pipelines cache reads with configurable latency, and guards every engine handshake with a timeout.
- Drives the projection, KV-cache, QK, softmax and attention-reader engines through start/done pulses only; it carries no datapath.

Parameters:
- D, 64, head_dim; number of projection input beats per token.
- SEQ_LEN, 2048, KV cache depth in tokens.
- RD_LAT, 1, KV cache read latency in cycles (1..4).
- WRAP_MODE, 1, cache-full policy: 1 = ring buffer overwriting the oldest token; 0 = reject the step with an error.
- TIMEOUT, 65535, maximum cycles to wait for any engine done; 0 disables timeouts.
- Derived: AW = $clog2(SEQ_LEN); LW = $clog2(SEQ_LEN+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one step; sampled only in IDLE
- clear  in  1  reset sequence length and write pointer; honoured only in IDLE
- proj_start  out  1  one-cycle pulse on the first projection beat
- proj_valid  out  1  high for D consecutive beats
- proj_done  in  1  projection result ready
- kv_we  out  1  one-cycle K/V cache write strobe
- kv_waddr  out  AW  write slot
- kv_rd_en  out  1  cache read request
- kv_raddr  out  AW  read slot
- ld_we  out  1  kv_rd_en delayed by RD_LAT; strobes load-buffer write
- ld_idx  out  AW  chronological buffer index, aligned with ld_we
- act_len  out  LW  valid token count for QK/softmax/reader
- qk_start, sm_start, ar_start  out  1  engine start pulses
- qk_done, sm_done, ar_done  in  1  engine completion
- busy  out  1  state != IDLE
- done  out  1  one-cycle step completion pulse
- err  out  1  qualifies done; 1 = step aborted
- err_code  out  2  0 none, 1 cache full (WRAP_MODE=0), 2 timeout
- err_stage  out  3  state in which the timeout fired

Behaviour:
- Reset: all outputs 0; state IDLE; len = 0; wr_ptr = 0. Reset mid-step aborts with no done pulse.
- All outputs are registered. Pulses last exactly one cycle.
- IDLE:
  - clear=1 sets len = 0 and wr_ptr = 0.
  - start=1 goes to PROJ. start wins over clear in the same cycle; clear is then ignored.
  - start while busy is ignored.
- PROJ:
  - proj_valid is high for D cycles; proj_start is high on the first of them.
  - Beat counter runs 0..D-1, then state goes to WAIT_PROJ.
  - proj_done is ignored before WAIT_PROJ.
- WAIT_PROJ: on proj_done, go to WRITE_KV.
- WRITE_KV:
  - If len==SEQ_LEN and WRAP_MODE=0: no write; done=1, err=1, err_code=1; go to IDLE; len and wr_ptr unchanged.
  - Otherwise: kv_we=1, kv_waddr=wr_ptr; wr_ptr increments modulo SEQ_LEN (wraps SEQ_LEN-1 -> 0); len = min(len+1, SEQ_LEN); go to LOAD.
- LOAD:
  - Issues len reads on consecutive cycles (kv_rd_en held high).
  - Read base = wr_ptr if len==SEQ_LEN, else 0; kv_raddr = (base + i) mod SEQ_LEN for i = 0..len-1.
  - ld_idx = i, delayed RD_LAT cycles together with ld_we.
  - After the last read, go to DRAIN.
- DRAIN: wait RD_LAT cycles so the last ld_we has been issued; go to QK.
- QK: qk_start=1, act_len=len; go to WAIT_QK.
- WAIT_QK: on qk_done, go to SM.
- SM: sm_start=1; go to WAIT_SM.
- WAIT_SM: on sm_done, go to AR.
- AR: ar_start=1; go to WAIT_AR.
- WAIT_AR: on ar_done, done=1, err=0; go to IDLE.
- Engine done inputs are sampled only in their own WAIT_* state, so stale or early pulses are ignored.
- Timeout:
  - A per-wait counter is cleared on entry to each WAIT_* state.
  - When TIMEOUT>0 and the counter reaches TIMEOUT-1 without the done: done=1, err=1, err_code=2, err_stage=state; go to IDLE.
  - len and wr_ptr keep their post-write values on a timeout.
- act_len holds len continuously (also after the step).
- Cycle count for a successful step: 1 (IDLE->PROJ) + D + proj wait + 1 + len + RD_LAT + 3 starts + engine waits.

Decomposition:
- Package attn_pkg:
  - state enum: IDLE, PROJ, WAIT_PROJ, WRITE_KV, LOAD, DRAIN, QK, WAIT_QK, SM, WAIT_SM, AR, WAIT_AR.
  - err_code constants.
- Sub-module attn_rd_delay: parametrised RD_LAT shift register carrying {ld_we, ld_idx}.

Test Plan (D=4, SEQ_LEN=8, RD_LAT=2, TIMEOUT=16 unless stated):
- Reset, then start; engines answer done 3 cycles after each start:
  - proj_valid high for exactly 4 cycles.
  - kv_waddr=0; one kv_rd_en with raddr 0; ld_we 2 cycles later with ld_idx 0.
  - done=1 and err=0; act_len=1.
- 10 steps with WRAP_MODE=1:
  - kv_waddr sequence is 0..7,0,1; act_len saturates at 8.
  - Step 10 reads raddr 2,3,4,5,6,7,0,1 with ld_idx 0..7.
- WRAP_MODE=0, 9th step: no kv_we; done=1, err=1, err_code=1; no qk_start; act_len stays 8.
- sm_done never asserted: exactly 16 cycles after entering WAIT_SM, done=1, err=1, err_code=2, err_stage=WAIT_SM; the next start runs normally.
- Stale or illegal inputs:
  - qk_done pulsed during PROJ is ignored; the bench still waits for the real qk_done.
  - start pulsed while busy is ignored.
  - clear with start in IDLE: start wins, len is not cleared.
- Mid-step and idle resets:
  - rst asserted during LOAD: next cycle all outputs 0, no done, and len/wr_ptr back to 0.
  - clear in IDLE after 3 steps: the next step writes slot 0 with act_len=1.
